// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: stage-bundle widths and elastic-stage state encoding.
package pipe_stage_skid_pkg;

  // M->W bundle field widths
  localparam int unsigned PC_W       = 32;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned WE_W       = 1;
  localparam int unsigned ALU_RES_W  = 32;
  localparam int unsigned LOAD_W     = 32;
  localparam int unsigned SIZE_W     = 2;
  localparam int unsigned FUNCT_W    = 3;
  localparam int unsigned INSTR_W    = 32;

  localparam int unsigned STAGE_DATA_W = PC_W + RD_W + WE_W + ALU_RES_W + LOAD_W +
                                         SIZE_W + FUNCT_W + INSTR_W;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Entries held in a given state (encoding chosen so it equals the count)
  function automatic logic [OCC_W-1:0] occupancy_of(input state_e s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter, reusable for performance counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready register with optional two-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W      = STAGE_DATA_W,
  parameter int unsigned SKID_EN     = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [OCC_W-1:0]       occupancy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occupancy_of(state_q);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // State and head-of-queue payload register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;

      // Ready comes from state only, so out_ready never reaches in_ready
      assign in_ready = (state_q != ST_TWO);

      // Next state / payload movement; flush beats every transfer
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_fire) begin
                state_d = ST_ONE;
                main_d  = in_data;
              end
            end
            ST_ONE: begin
              if (in_fire && !out_fire) begin
                state_d = ST_TWO;
                skid_d  = in_data;
              end else if (out_fire && !in_fire) begin
                state_d = ST_EMPTY;
                main_d  = '0;
              end else if (in_fire && out_fire) begin
                main_d  = in_data;
              end
            end
            ST_TWO: begin
              if (out_fire) begin
                state_d = ST_ONE;
                main_d  = skid_q;
                skid_d  = '0;
              end
            end
            default: begin
              state_d = ST_EMPTY;
              main_d  = '0;
              skid_d  = '0;
            end
          endcase
        end
      end

      // Second-entry payload register
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          skid_q <= '0;
        end else begin
          skid_q <= skid_d;
        end
      end
    end else begin : g_pass
      // Single entry: accept when empty or when the held entry leaves this cycle
      assign in_ready = !out_valid || out_ready;

      // Next state / payload for the single-register stage
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = '0;
        end else if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = '0;
        end
      end
    end
  endgenerate

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .count (stall_count)
  );

endmodule
